pc_gen: RTL

Parametrised successor to the single-cycle next-PC logic, for the pipelined core. Owns the fetch PC register and computes the next PC from branch, jump and jump-register redirects resolved in ID, plus an optional exception/eret redirect. Supports an IF stall and holds a redirect that arrives during a stall until the stall releases. Sits between the ID-stage decode/forwarding logic and the IF-stage instruction memory address.

---
 rtl/pc_gen_pkg.sv | 33 +++
 rtl/pc_gen_br_cmp.sv | 32 +++
 rtl/pc_gen.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared constants for the fetch PC generator.
// Branch-condition encodings and the default reset / exception vectors.
// The exception/eret path is enabled by the PC_GEN_EXC_EN macro.
package pc_gen_pkg;

    // Branch condition encodings carried on br_op.
    // Encodings 6 and 7 are reserved and never taken.
    localparam logic [2:0] BR_BEQ  = 3'd0;
    localparam logic [2:0] BR_BNE  = 3'd1;
    localparam logic [2:0] BR_BLEZ = 3'd2;
    localparam logic [2:0] BR_BGTZ = 3'd3;
    localparam logic [2:0] BR_BLTZ = 3'd4;
    localparam logic [2:0] BR_BGEZ = 3'd5;

    // Default vectors.
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;

    // Word-offset branch target: base + 4 + (imm << 2), wrapping modulo 2^32.
    function automatic logic [31:0] calc_br_target(input logic [31:0] base,
                                                   input logic [31:0] imm);
        return base + 32'd4 + (imm << 2);
    endfunction

    // Pseudo-direct jump target: top nibble of base + 4, index, two zero bits.
    function automatic logic [31:0] calc_j_target(input logic [31:0] base,
                                                  input logic [25:0] idx);
        logic [31:0] base4;
        base4 = base + 32'd4;
        return {base4[31:28], idx, 2'b00};
    endfunction

endpackage

// File: rtl/pc_gen_br_cmp.sv
// br_cmp: purely combinational branch-condition evaluator.
// Kept separate so later branch-prediction logic can reuse it.
module br_cmp
    import pc_gen_pkg::*;
(
    input  logic [2:0]  br_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        taken
);

    logic rs_zero;
    logic rs_neg;

    assign rs_zero = (rs_val == 32'd0);
    assign rs_neg  = rs_val[31];

    // Evaluate the selected condition; signed tests use the sign bit and zero flag.
    always_comb begin
        taken = 1'b0;
        case (br_op)
            BR_BEQ:  taken = (rs_val == rt_val);
            BR_BNE:  taken = (rs_val != rt_val);
            BR_BLEZ: taken = rs_neg || rs_zero;
            BR_BGTZ: taken = !rs_neg && !rs_zero;
            BR_BLTZ: taken = rs_neg;
            BR_BGEZ: taken = !rs_neg;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register and next-PC selection for the pipelined core.
// Redirects come from ID (branch, j/jal, jr/jalr). A redirect that arrives
// while IF is stalled is parked in a pending register and applied when the
// stall releases. Optional exception/eret redirect under PC_GEN_EXC_EN; it
// bypasses the stall and discards any pending redirect.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EXC_PC   = EXC_PC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    input  logic [31:0] id_pc,
    input  logic        br_en,
    input  logic [2:0]  br_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic [31:0] b_imm,
    input  logic        j_en,
    input  logic [25:0] j_imm26,
    input  logic        jr_en,
    input  logic [31:0] jr_target,
`ifdef PC_GEN_EXC_EN
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
`endif
    output logic        redirect,
    output logic        pend_valid
);

    logic [31:0] pc_q,          pc_d;
    logic        pend_valid_q,  pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;

    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] seq_pc;
    logic        redir_sel;
    logic        force_sel;    // exception/eret: ignores stall, drops pending
    logic [31:0] redir_target;

    br_cmp u_br_cmp (
        .br_op  (br_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .taken  (br_taken)
    );

    assign br_target = calc_br_target(id_pc, b_imm);
    assign j_target  = calc_j_target(id_pc, j_imm26);
    assign seq_pc    = pc_q + 32'd4;

`ifdef PC_GEN_EXC_EN
    // Priority select: exc > eret > jr > j > taken branch.
    always_comb begin
        redir_sel    = 1'b0;
        force_sel    = 1'b0;
        redir_target = seq_pc;
        if (exc_req) begin
            redir_sel    = 1'b1;
            force_sel    = 1'b1;
            redir_target = EXC_PC;
        end else if (eret_req) begin
            redir_sel    = 1'b1;
            force_sel    = 1'b1;
            redir_target = epc;
        end else if (jr_en) begin
            redir_sel    = 1'b1;
            redir_target = jr_target;
        end else if (j_en) begin
            redir_sel    = 1'b1;
            redir_target = j_target;
        end else if (br_en && br_taken) begin
            redir_sel    = 1'b1;
            redir_target = br_target;
        end
    end
`else
    // EXC_PC only matters when the exception path is built in.
    logic unused_exc_pc;
    assign unused_exc_pc = ^EXC_PC;

    // Priority select: jr > j > taken branch.
    always_comb begin
        redir_sel    = 1'b0;
        force_sel    = 1'b0;
        redir_target = seq_pc;
        if (jr_en) begin
            redir_sel    = 1'b1;
            redir_target = jr_target;
        end else if (j_en) begin
            redir_sel    = 1'b1;
            redir_target = j_target;
        end else if (br_en && br_taken) begin
            redir_sel    = 1'b1;
            redir_target = br_target;
        end
    end
`endif

    // Next-state for the PC and the pending-redirect registers.
    always_comb begin
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (force_sel) begin
            // Exception entry/return takes effect even while stalled.
            pc_d         = redir_target;
            pend_valid_d = 1'b0;
        end else if (stall) begin
            // Hold fetch; remember the newest redirect for later.
            if (redir_sel) begin
                pend_target_d = redir_target;
                pend_valid_d  = 1'b1;
            end
        end else begin
            // A fresh redirect outranks the parked one.
            if (redir_sel) begin
                pc_d = redir_target;
            end else if (pend_valid_q) begin
                pc_d = pend_target_q;
            end else begin
                pc_d = seq_pc;
            end
            pend_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign pc         = pc_q;
    assign pc4        = seq_pc;
    assign redirect   = redir_sel;
    assign pend_valid = pend_valid_q;

endmodule
